// File: rtl/iomem_pkg.sv
// iomem_pkg
// Shared definitions for the PicoSoC iomem sequencer: FSM state encoding,
// the default error word returned to the CPU, and the position of the slot
// field inside the CPU byte address.
// No ports (package only).

package iomem_pkg;

    // Sequencer states: wait for a request, wait for the slave, answer the CPU
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Read data handed back for unmapped slots and stalled slaves
    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

    // Slot number lives in iomem_addr[23:20]; the page byte sits above it
    localparam int SLOT_MSB = 23;
    localparam int SLOT_LSB = 20;

endpackage

// File: rtl/iomem_timeout.sv
// iomem_timeout
// Slave wait watchdog for iomem_ctrl. Counts the cycles spent in the ACCESS
// phase and flags when the count reaches TIMEOUT_CYCLES so the sequencer can
// abandon a slave that never answers. Only instantiated when the top is built
// with IOMEM_TIMEOUT_EN defined.
//
// Ports:
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset
//   start    in   pulse on the cycle a mapped request is accepted
//   active   in   high for every cycle the sequencer is in ACCESS
//   expired  out  count has reached TIMEOUT_CYCLES while active

module iomem_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic active,
    output logic expired
);

    logic [15:0] count_q;

    // The count restarts from zero as the request is accepted, so it reads 0
    // in the first ACCESS cycle and advances once per ACCESS cycle after that.
    // The sequencer always leaves ACCESS when expired is raised, so the count
    // never needs to saturate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (active) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expired = active && (count_q == 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/iomem_ctrl.sv
// iomem_ctrl
// Sequencer and address decoder for the PicoSoC iomem bus. Accepts one CPU
// transaction at a time on page BASE_PAGE, routes it to one of NUM_SLOTS
// peripheral slots and returns the slot's read data with a one-cycle
// iomem_ready pulse. Requests to unmapped slots are answered with ERR_WORD
// and raise the sticky err_flag.
//
// Build option: define IOMEM_TIMEOUT_EN to add a slave wait watchdog
// (iomem_timeout); a slave silent for TIMEOUT_CYCLES is abandoned and the CPU
// gets ERR_WORD plus err_flag. Without it ACCESS waits indefinitely.
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   iomem_valid  in   CPU request
//   iomem_ready  out  one-cycle completion pulse
//   iomem_wstrb  in   byte write strobes, 0 = read
//   iomem_addr   in   byte address (page [31:24], slot [23:20], offset [19:0])
//   iomem_wdata  in   write data
//   iomem_rdata  out  read data, valid while iomem_ready is high
//   slv_sel      out  one-hot slot select, held until the slave is ready
//   slv_wstrb    out  registered strobes
//   slv_addr     out  registered offset iomem_addr[19:0]
//   slv_wdata    out  registered write data
//   slv_ready    in   per-slot completion
//   slv_rdata    in   packed read data, slot k at [32k+31:32k]
//   err_flag     out  sticky error indicator
//   err_clr      in   clears err_flag (a simultaneous error event wins)

module iomem_ctrl
    import iomem_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [7:0]  BASE_PAGE      = 8'h03,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,
    output logic [NUM_SLOTS-1:0]    slv_sel,
    output logic [3:0]              slv_wstrb,
    output logic [19:0]             slv_addr,
    output logic [31:0]             slv_wdata,
    input  logic [NUM_SLOTS-1:0]    slv_ready,
    input  logic [32*NUM_SLOTS-1:0] slv_rdata,
    output logic                    err_flag,
    input  logic                    err_clr
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  slot_q;
    logic [3:0]  req_slot;
    logic        page_hit;
    logic        slot_mapped;
    logic        accept;
    logic        start_access;
    logic        load_slave;
    logic        err_event;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;

    assign req_slot    = iomem_addr[SLOT_MSB:SLOT_LSB];
    assign page_hit    = iomem_valid && (iomem_addr[31:24] == BASE_PAGE);
    assign slot_mapped = ({1'b0, req_slot} < 5'(NUM_SLOTS));

    // The select is decoded from the state register rather than stored, so the
    // asynchronous reset (which forces IDLE) drops it at once and it can never
    // outlive the ACCESS phase.
    always_comb begin
        slv_sel = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slv_sel[k] = (state == ACCESS) && (slot_q == 4'(k));
        end
    end

    // Only the selected slot's ready and data matter; masking with slv_sel
    // makes ready bits on every other slot invisible.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slv_sel[k]) begin
                sel_rdata = slv_rdata[32*k +: 32];
            end
        end
    end

    assign sel_ready = |(slv_ready & slv_sel);

`ifdef IOMEM_TIMEOUT_EN
    iomem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start_access),
        .active  (state == ACCESS),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // State register for the request sequencer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Requests are only looked at in IDLE, so the RESP
    // cycle can never double-accept a request the CPU has not yet dropped.
    // A slave that answers in the same cycle the watchdog expires is honoured.
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        start_access = 1'b0;
        load_slave   = 1'b0;
        err_event    = 1'b0;
        case (state)
            IDLE: begin
                if (page_hit) begin
                    accept = 1'b1;
                    if (slot_mapped) begin
                        start_access = 1'b1;
                        next_state   = ACCESS;
                    end else begin
                        err_event  = 1'b1;
                        next_state = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    load_slave = 1'b1;
                    next_state = RESP;
                end else if (timeout_hit) begin
                    err_event  = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign iomem_ready = (state == RESP);

    // Request capture: the slave-side outputs are loaded once on accept and
    // then held untouched for the whole ACCESS phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q    <= '0;
            slv_addr  <= '0;
            slv_wstrb <= '0;
            slv_wdata <= '0;
        end else if (accept) begin
            slot_q    <= req_slot;
            slv_addr  <= iomem_addr[19:0];
            slv_wstrb <= iomem_wstrb;
            slv_wdata <= iomem_wdata;
        end
    end

    // Response data: error word for unmapped or abandoned requests, the
    // selected slave's data otherwise (also on writes, where the CPU ignores
    // it). Holds its value between transactions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_rdata <= '0;
        end else if (err_event) begin
            iomem_rdata <= ERR_WORD;
        end else if (load_slave) begin
            iomem_rdata <= sel_rdata;
        end
    end

    // Sticky error flag; a new error in the same cycle as a clear must not be
    // lost, so the set has priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_flag <= 1'b0;
        end else if (err_event) begin
            err_flag <= 1'b1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iomem_ctrl.sv
// tb_iomem_ctrl
// Directed self-checking bench for iomem_ctrl (NUM_SLOTS=4, default page and
// error word). Expected read data is queued when a request is driven and
// popped when iomem_ready appears. Honours IOMEM_TIMEOUT_EN with an 8-cycle
// watchdog.

module tb_iomem_ctrl;

    localparam int          NUM_SLOTS  = 4;
    localparam int          TB_TIMEOUT = 8;
    localparam logic [31:0] ERR_WORD   = 32'hDEADBEEF;
    localparam logic [31:0] FILLER     = 32'h0BAD0BAD;

    logic                    clk;
    logic                    resetn;
    logic                    iomem_valid;
    logic                    iomem_ready;
    logic [3:0]              iomem_wstrb;
    logic [31:0]             iomem_addr;
    logic [31:0]             iomem_wdata;
    logic [31:0]             iomem_rdata;
    logic [NUM_SLOTS-1:0]    slv_sel;
    logic [3:0]              slv_wstrb;
    logic [19:0]             slv_addr;
    logic [31:0]             slv_wdata;
    logic [NUM_SLOTS-1:0]    slv_ready;
    logic [32*NUM_SLOTS-1:0] slv_rdata;
    logic                    err_flag;
    logic                    err_clr;

    int          vectors_applied = 0;
    int          miscompares     = 0;
    logic [31:0] exp_q[$];

    iomem_ctrl #(
        .NUM_SLOTS      (NUM_SLOTS),
        .BASE_PAGE      (8'h03),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .ERR_WORD       (ERR_WORD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .slv_sel     (slv_sel),
        .slv_wstrb   (slv_wstrb),
        .slv_addr    (slv_addr),
        .slv_wdata   (slv_wdata),
        .slv_ready   (slv_ready),
        .slv_rdata   (slv_rdata),
        .err_flag    (err_flag),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors_applied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive a CPU request and queue the read data the CPU should get back
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        exp_q.push_back(exp_rdata);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ready"}, 32'(iomem_ready), 32'd0);
        checkOutput({tag, " rdata"}, iomem_rdata, 32'd0);
        checkOutput({tag, " sel"}, 32'(slv_sel), 32'd0);
        checkOutput({tag, " wstrb"}, 32'(slv_wstrb), 32'd0);
        checkOutput({tag, " addr"}, 32'(slv_addr), 32'd0);
        checkOutput({tag, " wdata"}, slv_wdata, 32'd0);
        checkOutput({tag, " err"}, 32'(err_flag), 32'd0);
    endtask

    // One complete transaction. The slave raises ready after seeing its
    // select for delay+1 cycles; all other slots hold ready high throughout
    // to show they are ignored. Called at a sample point (#1 after posedge).
    task automatic run_txn(input string tag, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic [31:0] wdata,
                           input int delay, input logic [31:0] sdata,
                           input logic clr_at_accept, input bit expect_timeout);
        logic [3:0]  slot;
        bit          mapped;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          sel_cycles;
        int          lat;
        bit          done;
        slot       = addr[23:20];
        mapped     = (int'(slot) < NUM_SLOTS);
        exp_sel    = mapped ? 4'(1 << slot) : 4'b0;
        exp_rdata  = (mapped && !expect_timeout) ? sdata : ERR_WORD;
        exp_lat    = !mapped ? 1 : (expect_timeout ? TB_TIMEOUT + 2 : delay + 2);
        sel_cycles = 0;
        lat        = 0;
        done       = 1'b0;
        slv_rdata  = {NUM_SLOTS{FILLER}};
        if (mapped) slv_rdata[32*int'(slot) +: 32] = sdata;
        slv_ready  = mapped ? ~exp_sel : 4'b0;
        applyStimulus(addr, wstrb, wdata, exp_rdata);
        err_clr = clr_at_accept;
        for (int cyc = 1; cyc <= 50 && !done; cyc++) begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            if (iomem_ready) begin
                done = 1'b1;
                lat  = cyc;
            end else if (mapped) begin
                checkOutput({tag, " sel"}, 32'(slv_sel), 32'(exp_sel));
                checkOutput({tag, " slv_addr"}, 32'(slv_addr), {12'd0, addr[19:0]});
                checkOutput({tag, " slv_wstrb"}, 32'(slv_wstrb), 32'(wstrb));
                checkOutput({tag, " slv_wdata"}, slv_wdata, wdata);
                sel_cycles++;
                if (sel_cycles > delay) slv_ready = slv_ready | exp_sel;
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (done && exp_q.size() > 0) begin
            checkOutput({tag, " rdata"}, iomem_rdata, exp_q.pop_front());
            checkOutput({tag, " sel dropped"}, 32'(slv_sel), 32'd0);
        end
        iomem_valid = 1'b0;
        slv_ready   = '0;
        @(posedge clk);
        #1;
        checkOutput({tag, " ready pulse"}, 32'(iomem_ready), 32'd0);
        checkOutput({tag, " rdata hold"}, iomem_rdata, exp_rdata);
    endtask

    initial begin
        bit saw_any;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        slv_ready   = '0;
        slv_rdata   = '0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] read slot 1");
        run_txn("rd_slot1", 32'h0310_0004, 4'b0000, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b0);

        $display("[TB] write slot 0");
        run_txn("wr_slot0", 32'h0300_0000, 4'b0011, 32'hA5A5_00FF, 3, 32'h0000_1111, 1'b0, 1'b0);
        checkOutput("no err after mapped", 32'(err_flag), 32'd0);

        $display("[TB] unmapped slot 5 then clear");
        run_txn("unmapped5", 32'h0350_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("err set", 32'(err_flag), 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkOutput("err cleared", 32'(err_flag), 32'd0);

        $display("[TB] page mismatch");
        saw_any = 1'b0;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            saw_any = saw_any | iomem_ready | (|slv_sel) | err_flag;
        end
        iomem_valid = 1'b0;
        checkOutput("page mismatch quiet", 32'(saw_any), 32'd0);

        $display("[TB] unmapped slot 4 with simultaneous clear");
        run_txn("unmapped4", 32'h0340_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b1, 1'b0);
        checkOutput("set beats clear", 32'(err_flag), 32'd1);

`ifdef IOMEM_TIMEOUT_EN
        $display("[TB] slave timeout");
        run_txn("timeout", 32'h0320_0000, 4'b0000, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 1'b1);
        checkOutput("timeout err", 32'(err_flag), 32'd1);
        slv_rdata = {NUM_SLOTS{FILLER}};
        applyStimulus(32'h0320_0008, 4'b0000, 32'h0, 32'h0);
        saw_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            saw_any = saw_any | iomem_ready;
        end
`else
        $display("[TB] slave stall without watchdog");
        slv_rdata = {NUM_SLOTS{FILLER}};
        applyStimulus(32'h0320_0008, 4'b0000, 32'h0, 32'h0);
        saw_any = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            saw_any = saw_any | iomem_ready;
        end
`endif
        checkOutput("stall no ready", 32'(saw_any), 32'd0);
        checkOutput("stall sel", 32'(slv_sel), 32'b0100);

        $display("[TB] reset mid access");
        #2;
        resetn = 1'b0;
        #1;
        checkAllZero("abort");
        exp_q.delete();
        iomem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post reset idle", 32'(iomem_ready), 32'd0);

        $display("[TB] read slot 3 after reset");
        run_txn("rd_slot3", 32'h0330_0010, 4'b0000, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
